// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with stall/flush/branch redirect and a circular return-address stack.
// Optional misaligned-target trap is compiled in with `define PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter int                ADDR_W     = 32,
  parameter int                STEP       = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                RAS_DEPTH  = 8
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter int                ALIGN_BITS = 0,
  parameter logic [ADDR_W-1:0] TRAP_ADDR  = '0
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             flush,
  input  logic [ADDR_W-1:0]                flush_addr,
  input  logic                             branch_taken,
  input  logic [ADDR_W-1:0]                branch_target,
  input  logic                             call,
  input  logic [ADDR_W-1:0]                call_target,
  input  logic                             ret,
  input  logic                             clr_err,
  output logic [ADDR_W-1:0]                address,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_cnt,
  output logic                             ras_empty,
  output logic                             ras_full,
  output logic                             ras_ovf,
  output logic                             ras_unf
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic                             misalign
`endif
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] pc_reg, pc_next, pc_plus_step, base_pc;
  logic [ADDR_W-1:0] redir_target, ras_top;
  logic              redir_valid;
  logic [PTR_W-1:0]  top_reg, top_next, top_inc, top_dec;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ovf_reg, ovf_next, unf_reg, unf_next;
  logic              ovf_set, unf_set;
  logic              push_en;
  logic              call_bad;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  assign pc_plus_step = pc_reg + ADDR_W'(STEP);
  assign top_inc      = (top_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_reg + PTR_W'(1);
  assign top_dec      = (top_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : top_reg - PTR_W'(1);
  // Pop must reach the PC in the same cycle, so the stack is read asynchronously.
  assign ras_top      = ras_mem[top_reg];

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
  logic mis_next, mis_reg;
  assign call_bad = |(call_target & ALIGN_MASK);
`else
  assign call_bad = 1'b0;
`endif

  // Action select: flush > stall > ret > call > branch > increment.
  always_comb begin
    redir_valid  = 1'b0;
    redir_target = '0;
    base_pc      = pc_reg;
    top_next     = top_reg;
    cnt_next     = cnt_reg;
    push_en      = 1'b0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;
    if (flush) begin
      redir_valid  = 1'b1;
      redir_target = flush_addr;
    end else if (!stall) begin
      if (ret) begin
        if (cnt_reg != '0) begin
          redir_valid  = 1'b1;
          redir_target = ras_top;
          top_next     = top_dec;
          cnt_next     = cnt_reg - CNT_W'(1);
        end else begin
          base_pc = pc_plus_step;
          unf_set = 1'b1;
        end
      end else if (call) begin
        redir_valid  = 1'b1;
        redir_target = call_target;
        if (!call_bad) begin
          // When full, advancing top lands on the oldest entry and overwrites it.
          push_en  = 1'b1;
          top_next = top_inc;
          if (cnt_reg == CNT_W'(RAS_DEPTH)) ovf_set = 1'b1;
          else                             cnt_next = cnt_reg + CNT_W'(1);
        end
      end else if (branch_taken) begin
        redir_valid  = 1'b1;
        redir_target = branch_target;
      end else begin
        base_pc = pc_plus_step;
      end
    end
  end

  always_comb begin
    pc_next = redir_valid ? redir_target : base_pc;
`ifdef PC_MISALIGN_TRAP_EN
    mis_next = 1'b0;
    if (redir_valid && |(redir_target & ALIGN_MASK)) begin
      pc_next  = TRAP_ADDR;
      mis_next = 1'b1;
    end
`endif
  end

  // A flag being set in the same cycle beats clr_err.
  assign ovf_next = ovf_set | (ovf_reg & ~clr_err);
  assign unf_next = unf_set | (unf_reg & ~clr_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg  <= RESET_ADDR;
      top_reg <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      top_reg <= top_next;
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_reg <= 1'b0;
    else     mis_reg <= mis_next;
  end
  assign misalign = mis_reg;
`endif

  always_ff @(posedge clk) begin
    if (push_en && !rst) ras_mem[top_inc] <= pc_plus_step;
  end

  assign address   = pc_reg;
  assign ras_cnt   = cnt_reg;
  assign ras_empty = (cnt_reg == '0);
  assign ras_full  = (cnt_reg == CNT_W'(RAS_DEPTH));
  assign ras_ovf   = ovf_reg;
  assign ras_unf   = unf_reg;

endmodule
